pic_window_fetch_sched: RTL and testbench

//  Schedules reads of the single-port 256x256 picture ROM for two on-screen windows:
//  WIN1 shows the raw image, WIN2 shows the 3x3-filtered image.

---
 rtl/pic_window_fetch_sched_if.sv | 37 +++
 rtl/pic_window_fetch_sched.sv | 225 ++++++++++++++++++++++
 tb/tb_pic_window_fetch_sched.sv | 187 ++++++++++++++++++
 3 files changed

// File: rtl/pic_window_fetch_sched_if.sv
// +----------------------------------------------------------------------------+
// | Module      : pic_window_fetch_sched_if                                    |
// | Description : Timing-generator inputs and ROM fetch / display-select       |
// |               outputs of the picture window fetch scheduler.               |
// |               master = timing/datapath side, slave = the scheduler.        |
// | Revision    : 1.0  initial release                                         |
// +----------------------------------------------------------------------------+
`default_nettype none

interface pic_window_fetch_sched_if #(
   parameter int X_BITS = 12,
   parameter int Y_BITS = 12,
   parameter int ADDR_W = 16
);
   logic [X_BITS-1:0] act_x;
   logic [Y_BITS-1:0] act_y;
   logic              vs_in;
   logic              de_in;
   logic [ADDR_W-1:0] rom_addr;
   logic              rom_en;
   logic [1:0]        fetch_owner;
   logic [1:0]        sel_out;
   logic              frame_start;
   logic              conflict;

   modport master (
      output act_x, act_y, vs_in, de_in,
      input  rom_addr, rom_en, fetch_owner, sel_out, frame_start, conflict
   );

   modport slave (
      input  act_x, act_y, vs_in, de_in,
      output rom_addr, rom_en, fetch_owner, sel_out, frame_start, conflict
   );
endinterface

`default_nettype wire

// File: rtl/pic_window_fetch_sched.sv
// +----------------------------------------------------------------------------+
// | Module      : pic_window_fetch_sched                                       |
// | Description : Schedules single-port picture ROM reads for two windows      |
// |               (raw WIN1, filtered WIN2), fetching LEAD cycles ahead of     |
// |               display, arbitrating ROM ownership (WIN1 wins) and emitting  |
// |               a registered display window select.                          |
// |               Optional build macro PIC_SCHED_STATS_EN adds frame_cnt and   |
// |               conflict_cnt statistics outputs.                             |
// | Revision    : 1.0  initial release                                         |
// +----------------------------------------------------------------------------+
`default_nettype none

module pic_window_fetch_sched #(
   parameter int X_BITS = 12,
   parameter int Y_BITS = 12,
   parameter int ADDR_W = 16,
   parameter int PIC_W  = 256,
   parameter int PIC_H  = 256,
   parameter int WIN1_X = 640,
   parameter int WIN2_X = 1024,
   parameter int WIN_Y  = 412,
   parameter int LEAD   = 8
) (
   input  wire logic                 pix_clk,
   input  wire logic                 rstn,
   pic_window_fetch_sched_if.slave   bus
`ifdef PIC_SCHED_STATS_EN
   ,
   output logic [15:0]               frame_cnt,
   output logic [15:0]               conflict_cnt
`endif
);

   localparam int COL_W = (PIC_W > 1) ? $clog2(PIC_W) : 1;
   localparam logic [COL_W-1:0]  COL_LAST = COL_W'(PIC_W - 1);
   localparam logic [31:0] F1_LO = 32'(WIN1_X - LEAD);
   localparam logic [31:0] F2_LO = 32'(WIN2_X - LEAD);
   localparam logic [31:0] D1_LO = 32'(WIN1_X);
   localparam logic [31:0] D2_LO = 32'(WIN2_X);
   localparam logic [31:0] Y_LO  = 32'(WIN_Y);
   localparam logic [31:0] Y_HI  = 32'(WIN_Y + PIC_H);
   localparam logic [31:0] PW    = 32'(PIC_W);

   typedef enum logic [2:0] {
      S_IDLE     = 3'd0,
      S_WAIT_ROW = 3'd1,
      S_LINE     = 3'd2,
      S_FETCH1   = 3'd3,
      S_FETCH2   = 3'd4,
      S_DONE     = 3'd5
   } state_t;

   state_t            state_q, state_d;
   logic [ADDR_W-1:0] row_base_q, row_base_d;
   logic [COL_W-1:0]  col1_q, col1_d, col2_q, col2_d;
   logic              vs_dly_q, vs_dly_d, de_dly_q, de_dly_d;
   logic              line_hit_q, line_hit_d;
   logic [ADDR_W-1:0] rom_addr_q, rom_addr_d;
   logic              rom_en_q, rom_en_d;
   logic [1:0]        owner_q, owner_d;
   logic [1:0]        sel_q, sel_d;
   logic              frame_start_q, frame_start_d;
   logic              conflict_q, conflict_d;
`ifdef PIC_SCHED_STATS_EN
   logic [15:0]       frame_cnt_q, frame_cnt_d;
   logic [15:0]       conflict_cnt_q, conflict_cnt_d;
`endif

   logic [X_BITS-1:0] act_x_w;
   logic [Y_BITS-1:0] act_y_w;
   logic [31:0]       x_w, y_w;
   logic              y_in, y_start, y_past, vs_rise, de_fall, gate;
   logic              req1, req2;

   assign act_x_w = bus.act_x;
   assign act_y_w = bus.act_y;
   assign x_w     = 32'(act_x_w);
   assign y_w     = 32'(act_y_w);
   assign y_in    = (y_w >= Y_LO) && (y_w < Y_HI);
   assign y_start = (y_w == Y_LO);
   assign y_past  = (y_w >= Y_HI);
   assign vs_rise = bus.vs_in && !vs_dly_q;
   assign de_fall = de_dly_q && !bus.de_in;
   // Fetching is allowed inside the picture rows, including the very first
   // cycle of the first row so that a window starting at column 0 is not lost.
   assign gate    = (state_q == S_LINE) || (state_q == S_FETCH1) || (state_q == S_FETCH2) ||
                    ((state_q == S_WAIT_ROW) && y_start && bus.de_in);
   assign req1    = gate && bus.de_in && y_in && (x_w >= F1_LO) && (x_w < F1_LO + PW);
   assign req2    = gate && bus.de_in && y_in && (x_w >= F2_LO) && (x_w < F2_LO + PW);

   // Next-state, address generation, arbitration and output decode
   always_comb begin
      state_d       = state_q;
      row_base_d    = row_base_q;
      col1_d        = col1_q;
      col2_d        = col2_q;
      line_hit_d    = line_hit_q;
      conflict_d    = conflict_q;
      vs_dly_d      = bus.vs_in;
      de_dly_d      = bus.de_in;
      frame_start_d = vs_rise;
      rom_en_d      = 1'b0;
      owner_d       = 2'b00;
      rom_addr_d    = '0;
      sel_d         = 2'b00;
`ifdef PIC_SCHED_STATS_EN
      frame_cnt_d    = frame_cnt_q;
      conflict_cnt_d = conflict_cnt_q;
`endif

      if (bus.de_in && y_in && (x_w >= D1_LO) && (x_w < D1_LO + PW)) begin
         sel_d = 2'b01;
      end else if (bus.de_in && y_in && (x_w >= D2_LO) && (x_w < D2_LO + PW)) begin
         sel_d = 2'b10;
      end

      if (vs_rise) begin
         // A new frame aborts whatever picture was in progress
         state_d    = S_WAIT_ROW;
         row_base_d = '0;
         col1_d     = '0;
         col2_d     = '0;
         line_hit_d = 1'b0;
         conflict_d = 1'b0;
`ifdef PIC_SCHED_STATS_EN
         frame_cnt_d = frame_cnt_q + 16'd1;
`endif
      end else begin
         if (req1) begin
            rom_en_d   = 1'b1;
            owner_d    = 2'b01;
            rom_addr_d = row_base_q + ADDR_W'(col1_q);
         end else if (req2) begin
            rom_en_d   = 1'b1;
            owner_d    = 2'b10;
            rom_addr_d = row_base_q + ADDR_W'(col2_q);
         end
         if (req1 && req2) begin
            conflict_d = 1'b1;
`ifdef PIC_SCHED_STATS_EN
            if (conflict_cnt_q != 16'hFFFF) conflict_cnt_d = conflict_cnt_q + 16'd1;
`endif
         end
         // The losing window still advances so its image stays in order
         if (req1 && (col1_q != COL_LAST)) col1_d = col1_q + 1'b1;
         if (req2 && (col2_q != COL_LAST)) col2_d = col2_q + 1'b1;
         if (gate && bus.de_in && y_in) line_hit_d = 1'b1;
         if (de_fall) begin
            if (line_hit_q) row_base_d = row_base_q + ADDR_W'(PIC_W);
            col1_d     = '0;
            col2_d     = '0;
            line_hit_d = 1'b0;
         end

         case (state_q)
            S_IDLE:     state_d = S_IDLE;
            S_WAIT_ROW: if (y_start && bus.de_in) state_d = S_LINE;
            S_LINE: begin
               if (y_past)                          state_d = S_DONE;
               else if (req1 && col1_q != COL_LAST) state_d = S_FETCH1;
               else if (req2 && col2_q != COL_LAST) state_d = S_FETCH2;
            end
            S_FETCH1:   if (de_fall || (req1 && col1_q == COL_LAST)) state_d = S_LINE;
            S_FETCH2:   if (de_fall || (req2 && col2_q == COL_LAST)) state_d = S_LINE;
            S_DONE:     state_d = S_DONE;
            default:    state_d = S_IDLE;
         endcase
      end
   end

   // State and registered outputs, cleared asynchronously
   always_ff @(posedge pix_clk or negedge rstn) begin
      if (!rstn) begin
         state_q       <= S_IDLE;
         row_base_q    <= '0;
         col1_q        <= '0;
         col2_q        <= '0;
         line_hit_q    <= 1'b0;
         conflict_q    <= 1'b0;
         vs_dly_q      <= 1'b0;
         de_dly_q      <= 1'b0;
         frame_start_q <= 1'b0;
         rom_en_q      <= 1'b0;
         owner_q       <= 2'b00;
         rom_addr_q    <= '0;
         sel_q         <= 2'b00;
`ifdef PIC_SCHED_STATS_EN
         frame_cnt_q    <= 16'd0;
         conflict_cnt_q <= 16'd0;
`endif
      end else begin
         state_q       <= state_d;
         row_base_q    <= row_base_d;
         col1_q        <= col1_d;
         col2_q        <= col2_d;
         line_hit_q    <= line_hit_d;
         conflict_q    <= conflict_d;
         vs_dly_q      <= vs_dly_d;
         de_dly_q      <= de_dly_d;
         frame_start_q <= frame_start_d;
         rom_en_q      <= rom_en_d;
         owner_q       <= owner_d;
         rom_addr_q    <= rom_addr_d;
         sel_q         <= sel_d;
`ifdef PIC_SCHED_STATS_EN
         frame_cnt_q    <= frame_cnt_d;
         conflict_cnt_q <= conflict_cnt_d;
`endif
      end
   end

   assign bus.rom_addr    = rom_addr_q;
   assign bus.rom_en      = rom_en_q;
   assign bus.fetch_owner = owner_q;
   assign bus.sel_out     = sel_q;
   assign bus.frame_start = frame_start_q;
   assign bus.conflict    = conflict_q;
`ifdef PIC_SCHED_STATS_EN
   assign frame_cnt    = frame_cnt_q;
   assign conflict_cnt = conflict_cnt_q;
`endif

endmodule

`default_nettype wire

// File: tb/tb_pic_window_fetch_sched.sv
// +----------------------------------------------------------------------------+
// | Module      : tb_pic_window_fetch_sched                                    |
// | Description : Randomized self-checking bench for pic_window_fetch_sched on |
// |               a scaled-down raster (16x8 picture, overlapping windows).    |
// | Revision    : 1.0  initial release                                         |
// +----------------------------------------------------------------------------+
`default_nettype none

module tb_pic_window_fetch_sched;

   localparam int TB_W  = 16;
   localparam int TB_H  = 8;
   localparam int W1    = 40;
   localparam int W2    = 50;
   localparam int WY    = 5;
   localparam int LD    = 4;
   localparam int AW    = 7;
   localparam int H_ACT = 100;
   localparam int H_TOT = 110;
   localparam int V_TOT = 16;
   localparam int N_FR  = 7;

   logic pix_clk = 1'b0;
   logic rstn    = 1'b0;

   pic_window_fetch_sched_if #(.X_BITS(12), .Y_BITS(12), .ADDR_W(AW)) bus_if ();

`ifdef PIC_SCHED_STATS_EN
   logic [15:0] frame_cnt, conflict_cnt;
`endif

   pic_window_fetch_sched #(
      .X_BITS(12), .Y_BITS(12), .ADDR_W(AW), .PIC_W(TB_W), .PIC_H(TB_H),
      .WIN1_X(W1), .WIN2_X(W2), .WIN_Y(WY), .LEAD(LD)
   ) u_dut (
      .pix_clk (pix_clk),
      .rstn    (rstn),
      .bus     (bus_if)
`ifdef PIC_SCHED_STATS_EN
      ,
      .frame_cnt    (frame_cnt),
      .conflict_cnt (conflict_cnt)
`endif
   );

   always #5 pix_clk = ~pix_clk;

   int n_vec = 0;
   int n_err = 0;

   // Reference model: frame phase (0 idle, 1 waiting for first row,
   // 2 inside picture rows, 3 done), completed picture lines, per-line
   // request counts of each window.
   int m_mode, m_lines, m_c1, m_c2, m_fcnt, m_ccnt;
   bit m_hit, m_conf, m_de_p, m_vs_p;
   bit e_en, e_fs;
   int e_own, e_addr, e_sel;

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d at t=%0t", tag, got, exp, $time);
      end
   endtask

   task automatic model_reset();
      m_mode = 0; m_lines = 0; m_c1 = 0; m_c2 = 0; m_fcnt = 0; m_ccnt = 0;
      m_hit = 0; m_conf = 0; m_de_p = 0; m_vs_p = 0;
   endtask

   function automatic bit in_rng(input int v, input int lo, input int len);
      return (v >= lo) && (v < lo + len);
   endfunction

   task automatic model_step(input int x, input int y, input bit de, input bit vs);
      bit rise, fall, yin, act, r1, r2;
      rise = vs && !m_vs_p;
      fall = m_de_p && !de;
      yin  = in_rng(y, WY, TB_H);
      e_sel = (de && yin && in_rng(x, W1, TB_W)) ? 1 :
              (de && yin && in_rng(x, W2, TB_W)) ? 2 : 0;
      e_fs = rise; e_en = 0; e_own = 0; e_addr = 0;
      if (rise) begin
         m_mode = 1; m_lines = 0; m_c1 = 0; m_c2 = 0; m_hit = 0; m_conf = 0;
         m_fcnt = (m_fcnt + 1) % 65536;
      end else begin
         act = (m_mode == 2) || (m_mode == 1 && y == WY && de);
         r1  = act && de && yin && in_rng(x, W1 - LD, TB_W);
         r2  = act && de && yin && in_rng(x, W2 - LD, TB_W);
         if (r1) begin
            e_en = 1; e_own = 1; e_addr = (m_lines * TB_W + m_c1) % (1 << AW);
         end else if (r2) begin
            e_en = 1; e_own = 2; e_addr = (m_lines * TB_W + m_c2) % (1 << AW);
         end
         if (r1 && r2) begin
            m_conf = 1;
            if (m_ccnt < 65535) m_ccnt++;
         end
         if (r1 && m_c1 < TB_W - 1) m_c1++;
         if (r2 && m_c2 < TB_W - 1) m_c2++;
         if (act && de && yin) m_hit = 1;
         if (fall) begin
            if (m_hit) m_lines++;
            m_c1 = 0; m_c2 = 0; m_hit = 0;
         end
         if (m_mode == 1 && y == WY && de) m_mode = 2;
         else if (m_mode == 2 && y >= WY + TB_H) m_mode = 3;
      end
      m_vs_p = vs;
      m_de_p = de;
   endtask

   task automatic compare_all();
      check_val("rom_en", 32'(bus_if.rom_en), 32'(e_en));
      check_val("fetch_owner", 32'(bus_if.fetch_owner), 32'(e_own));
      if (e_en) check_val("rom_addr", 32'(bus_if.rom_addr), 32'(e_addr));
      check_val("sel_out", 32'(bus_if.sel_out), 32'(e_sel));
      check_val("frame_start", 32'(bus_if.frame_start), 32'(e_fs));
      check_val("conflict", 32'(bus_if.conflict), 32'(m_conf));
`ifdef PIC_SCHED_STATS_EN
      check_val("frame_cnt", 32'(frame_cnt), 32'(m_fcnt));
      check_val("conflict_cnt", 32'(conflict_cnt), 32'(m_ccnt));
`endif
   endtask

   task automatic cyc(input int x, input int y, input bit de, input bit vs);
      bus_if.act_x = 12'(x);
      bus_if.act_y = 12'(y);
      bus_if.de_in = de;
      bus_if.vs_in = vs;
      model_step(x, y, de, vs);
      @(posedge pix_clk);
      #1;
      compare_all();
   endtask

   task automatic check_cleared(input string tag);
      check_val({tag, "_rom_en"}, 32'(bus_if.rom_en), 32'd0);
      check_val({tag, "_owner"}, 32'(bus_if.fetch_owner), 32'd0);
      check_val({tag, "_rom_addr"}, 32'(bus_if.rom_addr), 32'd0);
      check_val({tag, "_sel"}, 32'(bus_if.sel_out), 32'd0);
      check_val({tag, "_fs"}, 32'(bus_if.frame_start), 32'd0);
      check_val({tag, "_conflict"}, 32'(bus_if.conflict), 32'd0);
   endtask

   initial begin
      int cut;
      bit vs;
      bus_if.act_x = '0;
      bus_if.act_y = '0;
      bus_if.de_in = 1'b0;
      bus_if.vs_in = 1'b0;
      model_reset();
      repeat (3) @(posedge pix_clk);
      #1;
      check_cleared("reset");
      rstn = 1'b1;

      for (int f = 0; f < N_FR; f++) begin
         for (int y = 0; y < V_TOT; y++) begin
            cut = ($urandom_range(0, 4) == 0 && f != 3) ? $urandom_range(20, H_ACT - 1) : H_ACT;
            for (int x = 0; x < H_TOT; x++) begin
               vs = (y == V_TOT - 2) ||
                    (f == 2 && y == WY + 3 && x >= H_ACT + 2 && x < H_ACT + 5);
               cyc(x, y, (x < cut), vs);
               if (f == 3 && y == WY + 2 && x == 45) begin
                  // Asynchronous reset in the middle of a fetch
                  rstn = 1'b0;
                  #1;
                  check_cleared("async_rst");
                  model_reset();
                  repeat (2) @(posedge pix_clk);
                  #1;
                  rstn = 1'b1;
               end
            end
         end
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

`default_nettype wire
